// File: rtl/btn_debounce_array.sv
// N-channel button front end: per-channel synchroniser and stable-count debounce filter,
// one mutual-exclusion group, registered level/press/release outputs and auto-repeat pulses.
module btn_debounce_array #(
    parameter int NUM_BTNS       = 7,
    parameter int DEBOUNCE_DELAY = 1000000,
    parameter int SYNC_STAGES    = 2,
    parameter int REPEAT_DELAY   = 25000000,
    parameter int REPEAT_PERIOD  = 5000000,
    parameter logic [NUM_BTNS-1:0] EXCL_MASK = NUM_BTNS'(7'b0001111),
    localparam int CNT_MAX = (DEBOUNCE_DELAY > REPEAT_DELAY)
                           ? ((DEBOUNCE_DELAY > REPEAT_PERIOD) ? DEBOUNCE_DELAY : REPEAT_PERIOD)
                           : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD),
    localparam int CNT_W   = $clog2(CNT_MAX + 32'sd1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] raw_btn,
    input  logic [NUM_BTNS-1:0] repeat_en,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_repeat
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_DELAY - 32'sd1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 32'sd1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    logic [NUM_BTNS-1:0] sync_r [SYNC_STAGES];
    logic [NUM_BTNS-1:0] sync_s;
    logic [NUM_BTNS-1:0] filt_r;
    logic [CNT_W-1:0]    dcnt_r [NUM_BTNS];
    logic [CNT_W-1:0]    rcnt_r [NUM_BTNS];
    logic [NUM_BTNS-1:0] ph_r;
    logic                grp_conflict_s;
    logic [NUM_BTNS-1:0] mask_s;
    logic [NUM_BTNS-1:0] rep_fire_s;

    // True when more than one bit of v is set.
    function automatic logic multi_hot(input logic [NUM_BTNS-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            multi = multi | (seen & v[i]);
            seen  = seen | v[i];
        end
        return multi;
    endfunction

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser shift chain for the asynchronous pad levels.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= '0;
            end
        end else begin
            sync_r[0] <= raw_btn;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Debounce filter: the filtered state flips only after DEBOUNCE_DELAY consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!reset) begin
            filt_r <= '0;
            for (int i = 0; i < NUM_BTNS; i++) begin
                dcnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (sync_s[i] == filt_r[i]) begin
                    dcnt_r[i] <= '0;
                end else if (dcnt_r[i] == DB_LAST) begin
                    filt_r[i] <= sync_s[i];
                    dcnt_r[i] <= '0;
                end else begin
                    dcnt_r[i] <= dcnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Exclusion group: any two active members mask every member of the group.
    always_comb begin
        grp_conflict_s = multi_hot(filt_r & EXCL_MASK);
        mask_s         = filt_r & ~(EXCL_MASK & {NUM_BTNS{grp_conflict_s}});
    end

    // Auto-repeat compare: initial delay in phase 0, periodic interval in phase 1.
    always_comb begin
        rep_fire_s = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            rep_fire_s[i] = btn_level[i] & repeat_en[i]
                          & (ph_r[i] ? (rcnt_r[i] == RP_LAST) : (rcnt_r[i] == RD_LAST));
        end
    end

    // Auto-repeat counters; dropping the level or the enable restarts the initial delay.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ph_r <= '0;
            for (int i = 0; i < NUM_BTNS; i++) begin
                rcnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (!btn_level[i] || !repeat_en[i]) begin
                    rcnt_r[i] <= '0;
                    ph_r[i]   <= 1'b0;
                end else if (rep_fire_s[i]) begin
                    rcnt_r[i] <= '0;
                    ph_r[i]   <= 1'b1;
                end else begin
                    rcnt_r[i] <= rcnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Registered outputs; a press always carries a repeat pulse with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_repeat  <= '0;
        end else begin
            btn_level   <= mask_s;
            btn_press   <= mask_s & ~btn_level;
            btn_release <= ~mask_s & btn_level;
            btn_repeat  <= (mask_s & ~btn_level) | rep_fire_s;
        end
    end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Bench for btn_debounce_array: per-cycle scoreboard against a behavioural model, a phase table
// with hand-derived levels, and hand-written timing sequences.
module tb_btn_debounce_array;

    localparam int RD = 6;
    localparam int RP = 3;
    localparam int DD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw_btn;
    logic [3:0] repeat_en;
    logic [3:0] btn_level, btn_press, btn_release, btn_repeat;

    btn_debounce_array #(
        .NUM_BTNS(4), .DEBOUNCE_DELAY(DD), .SYNC_STAGES(2),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .EXCL_MASK(4'b0011)
    ) dut (
        .clk(clk), .reset(reset), .raw_btn(raw_btn), .repeat_en(repeat_en),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] rep;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string      nm;
        logic [3:0] raw;
        logic [3:0] ren;
        logic       rst;
        int         ncyc;
        logic [3:0] exp_lvl;
    } vec_t;
    vec_t vt[10];

    // behavioural model state
    logic [3:0] m_sync0 = 4'b0, m_sync1 = 4'b0, m_s = 4'b0, m_level = 4'b0, m_ph = 4'b0;
    int         m_cnt[4];
    int         m_rcnt[4];

    logic [3:0] d_lvl, d_prs, d_rel, d_rep;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle, predict the outputs of that edge, then compare after the edge.
    task automatic step(input logic [3:0] r, input logic [3:0] en, input logic rs);
        exp_t       e;
        exp_t       got;
        logic [3:0] m;
        logic [3:0] fire;
        logic       conf;
        raw_btn   = r;
        repeat_en = en;
        reset     = rs;
        if (!rs) begin
            m_sync0 = 4'b0; m_sync1 = 4'b0; m_s = 4'b0; m_level = 4'b0; m_ph = 4'b0;
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0;
                m_rcnt[i] = 0;
            end
            e = '{lvl: 4'b0, prs: 4'b0, rel: 4'b0, rep: 4'b0};
        end else begin
            conf = ($countones(m_s & 4'b0011) > 1);
            m    = m_s & ~(conf ? 4'b0011 : 4'b0000);
            for (int i = 0; i < 4; i++) begin
                fire[i] = m_level[i] && en[i] &&
                          (m_ph[i] ? (m_rcnt[i] == RP - 1) : (m_rcnt[i] == RD - 1));
                if (!m_level[i] || !en[i]) begin
                    m_rcnt[i] = 0;
                    m_ph[i] = 1'b0;
                end else if (fire[i]) begin
                    m_rcnt[i] = 0;
                    m_ph[i] = 1'b1;
                end else begin
                    m_rcnt[i] = m_rcnt[i] + 1;
                end
                if (m_sync1[i] == m_s[i]) begin
                    m_cnt[i] = 0;
                end else if (m_cnt[i] == DD - 1) begin
                    m_s[i] = m_sync1[i];
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            e = '{lvl: m, prs: m & ~m_level, rel: ~m & m_level, rep: (m & ~m_level) | fire};
            m_sync1 = m_sync0;
            m_sync0 = r;
            m_level = m;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        d_lvl = btn_level; d_prs = btn_press; d_rel = btn_release; d_rep = btn_repeat;
        got = sb.pop_front();
        chk("scoreboard {lvl,prs,rel,rep}", {16'h0, d_lvl, d_prs, d_rel, d_rep},
            {16'h0, got.lvl, got.prs, got.rel, got.rep});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt_a, cnt_b;
        raw_btn = 4'b0; repeat_en = 4'b0; reset = 1'b0;

        vt[0] = '{"tbl_reset",       4'b0000, 4'b0000, 1'b0, 1, 4'b0000};
        vt[1] = '{"tbl_idle",        4'b0000, 4'b0000, 1'b1, 8, 4'b0000};
        vt[2] = '{"tbl_ch2",         4'b0100, 4'b1111, 1'b1, 8, 4'b0100};
        vt[3] = '{"tbl_ch2_ch3",     4'b1100, 4'b1111, 1'b1, 8, 4'b1100};
        vt[4] = '{"tbl_add_ch0",     4'b1101, 4'b1111, 1'b1, 8, 4'b1101};
        vt[5] = '{"tbl_conflict",    4'b1111, 4'b1111, 1'b1, 8, 4'b1100};
        vt[6] = '{"tbl_conflict_off",4'b1101, 4'b1111, 1'b1, 8, 4'b1101};
        vt[7] = '{"tbl_all_off",     4'b0000, 4'b0000, 1'b1, 8, 4'b0000};
        vt[8] = '{"tbl_glitch",      4'b1111, 4'b0000, 1'b1, 1, 4'b0000};
        vt[9] = '{"tbl_after_glitch",4'b0000, 4'b0000, 1'b1, 8, 4'b0000};

        for (int v = 0; v < 10; v++) begin
            cnt_a = 0;
            for (int c = 0; c < vt[v].ncyc; c++) begin
                step(vt[v].raw, vt[v].ren, vt[v].rst);
                if (v == 9 && (d_prs != 4'b0 || d_rel != 4'b0 || d_rep != 4'b0)) cnt_a++;
            end
            chk(vt[v].nm, {28'h0, d_lvl}, {28'h0, vt[v].exp_lvl});
            if (v == 9) chk("glitch_activity", cnt_a, 0);
        end

        // clean press, auto-repeat, release on channel 2
        step(4'b0, 4'b0, 1'b0);
        chk("reset_outputs", {16'h0, d_lvl, d_prs, d_rel, d_rep}, 32'h0);
        for (int k = 0; k <= 34; k++) begin
            step((k < 26) ? 4'b0100 : 4'b0000, 4'b0100, 1'b1);
            if (k == 5) chk("press_lvl_early", d_lvl[2], 0);
            if (k == 6) begin
                chk("press_lvl", d_lvl[2], 1);
                chk("press_pulse", d_prs[2], 1);
            end
            if (k == 7) chk("press_pulse_gone", d_prs[2], 0);
            if (k >= 6 && k <= 26)
                chk($sformatf("repeat_k%0d", k), d_rep[2],
                    (k == 6 || k == 12 || k == 15 || k == 18 || k == 21 || k == 24) ? 1 : 0);
            if (k >= 31 && k <= 33) chk($sformatf("release_k%0d", k), d_rel[2], (k == 32) ? 1 : 0);
        end

        // repeat disabled: only the press-coincident pulse
        step(4'b0, 4'b0, 1'b0);
        cnt_a = 0;
        for (int k = 0; k < 30; k++) begin
            step(4'b0100, 4'b0000, 1'b1);
            cnt_a += int'(d_rep[2]);
        end
        chk("norepeat_pulses", cnt_a, 1);

        // bounce on channel 3
        step(4'b0, 4'b0, 1'b0);
        cnt_a = 0;
        for (int k = 0; k <= 16; k++) begin
            step((k == 3) ? 4'b0000 : 4'b1000, 4'b0000, 1'b1);
            cnt_a += int'(d_prs[3]);
            if (k == 9) chk("bounce_lvl_early", d_lvl[3], 0);
            if (k == 10) chk("bounce_lvl", d_lvl[3], 1);
        end
        chk("bounce_press_count", cnt_a, 1);

        // exclusion between channels 0 and 1
        step(4'b0, 4'b0, 1'b0);
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k <= 35; k++) begin
            step((k < 10 || k >= 26) ? 4'b0001 : 4'b0011, 4'b0000, 1'b1);
            if (k >= 10 && k <= 30) cnt_a += int'(d_rel[0]);
            cnt_b += int'(d_prs[1]);
            if (k == 15) chk("excl_held", d_lvl[0], 1);
            if (k == 16) begin
                chk("excl_masked", {30'h0, d_lvl[1:0]}, 0);
                chk("excl_release", d_rel[0], 1);
            end
            if (k == 31) chk("excl_still_masked", d_lvl[0], 0);
            if (k == 32) begin
                chk("excl_repress", d_prs[0], 1);
                chk("excl_relevel", d_lvl[0], 1);
            end
        end
        chk("excl_release_count", cnt_a, 1);
        chk("excl_ch1_presses", cnt_b, 0);

        // reset in the middle of an active repeat
        step(4'b0, 4'b0, 1'b0);
        for (int k = 0; k <= 24; k++) begin
            step(4'b0100, 4'b0100, (k == 15) ? 1'b0 : 1'b1);
            if (k == 14) chk("midrst_before", d_lvl[2], 1);
            if (k == 15) chk("midrst_cleared", {16'h0, d_lvl, d_prs, d_rel, d_rep}, 0);
            if (k == 16) chk("midrst_no_release", d_rel[2], 0);
            if (k == 21) chk("midrst_lvl_early", d_lvl[2], 0);
            if (k == 22) chk("midrst_repress", d_prs[2], 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce_array.md
Name: btn_debounce_array

Overview:
- Parametrised N-channel successor to the per-button debouncer used in the game front end.
- Each raw pad input passes through a metastability synchroniser and a stable-for-N-cycles debounce filter.
- Provides a debounced level per channel, one-cycle press and release pulses, and optional auto-repeat pulses for held buttons.
- Supports one configurable mutual-exclusion group, such as the D-pad, that generalises the fixed up/down/left/right and A/B masking.
- Sits between the board button pins and the game controller FSM.

Parameters:
- NUM_BTNS, 7, number of independent channels (>=1).
- DEBOUNCE_DELAY, 1000000, consecutive cycles a synchronised input must differ from the filtered state before the filtered state flips (>=1).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- REPEAT_DELAY, 25000000, cycles from press to the first auto-repeat pulse (>=1).
- REPEAT_PERIOD, 5000000, cycles between later auto-repeat pulses (>=1).
- EXCL_MASK, 7'b0001111, channels forming the mutual-exclusion group (0 disables the group).
- CNT_W, derived as $clog2(max(DEBOUNCE_DELAY,REPEAT_DELAY,REPEAT_PERIOD)+1), counter width; not to be overridden.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-low reset.
- raw_btn, input, NUM_BTNS, asynchronous raw button levels, active high.
- repeat_en, input, NUM_BTNS, per-channel auto-repeat enable (synchronous to clk).
- btn_level, output, NUM_BTNS, debounced and exclusion-masked level.
- btn_press, output, NUM_BTNS, one-cycle pulse on a btn_level rise.
- btn_release, output, NUM_BTNS, one-cycle pulse on a btn_level fall.
- btn_repeat, output, NUM_BTNS, one-cycle pulse at press and at each auto-repeat interval.

Behaviour:
- Reset: one clock edge with reset==0 clears the following to 0.
  - All synchroniser flops.
  - Filtered state s[i], debounce counters and repeat counters.
  - btn_level, btn_press, btn_release and btn_repeat.
  - No release pulse is generated by a reset.
  - Reset applies mid-debounce and mid-repeat, and takes effect at the next edge.
- Synchroniser: a SYNC_STAGES-deep shift of raw_btn[i]; sync[i] is the last stage.
- Debounce per channel, evaluated each edge:
  - If sync==s: cnt<=0.
  - Else if cnt==DEBOUNCE_DELAY-1: s<=sync, cnt<=0.
  - Else: cnt<=cnt+1.
  - Any bounce back to s before the count completes restarts the count from 0.
- Exclusion:
  - Compute grp_conflict = (number of set bits in s & EXCL_MASK) > 1.
  - m[i] = s[i] & ~(EXCL_MASK[i] & grp_conflict).
  - If a second group member becomes active, the held member is masked, so both read 0 and a release is emitted for the previously held member.
  - When the conflict clears, the surviving member presses again.
  - Channels outside EXCL_MASK are unaffected.
- Outputs, all registered from m:
  - btn_level<=m.
  - btn_press<=m&~btn_level.
  - btn_release<=~m&btn_level.
  - Latency: outputs change SYNC_STAGES+DEBOUNCE_DELAY edges after the first edge that samples a new stable raw value.
- Auto-repeat per channel uses rcnt (CNT_W bits) and phase flag ph (0=initial delay, 1=periodic).
  - btn_repeat is asserted in the same cycle as btn_press, regardless of repeat_en.
  - While btn_level==1 and repeat_en==1, rcnt increments each cycle.
  - With ph==0, when rcnt reaches REPEAT_DELAY-1: pulse btn_repeat, rcnt<=0, ph<=1.
  - With ph==1, when rcnt reaches REPEAT_PERIOD-1: pulse, rcnt<=0.
  - Pulses therefore land at P, P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_PERIOD, and so on, where P is the press cycle.
  - btn_level==0 or repeat_en==0: rcnt<=0, ph<=0.
  - Deasserting repeat_en while a button is held and re-enabling it restarts the initial delay.
- Simultaneous events: channels are fully independent except through the exclusion group. Press and release can never both assert on one channel in the same cycle.
- No wrap-around: counters are bounded by their compare values.

Test Plan (NUM_BTNS=4, EXCL_MASK=4'b0011, SYNC_STAGES=2, DEBOUNCE_DELAY=4, REPEAT_DELAY=6, REPEAT_PERIOD=3):
- Clean press: raw_btn[2] 0->1, sampled at edge 0 and held. Required: btn_level[2]=1 and btn_press[2]=btn_repeat[2]=1 after edge 6; btn_press low after edge 7. Release after 20 cycles gives btn_release[2] one cycle, 6 edges after the fall.
- Bounce: raw_btn[3] high for 3 cycles, low for 1, then high for 10. Required: the counter restarts; btn_level[3] rises only 6 edges after the final rise; exactly one btn_press.
- Auto-repeat: raw_btn[2] held 20 cycles after press cycle P, with repeat_en[2]=1. Required: btn_repeat at P, P+6, P+9, P+12, P+15, P+18. With repeat_en=0, btn_repeat only at P.
- Exclusion:
  - btn 0 held and pressed; raw_btn[1] then raised and held. Required: when s[1] rises, btn_level[0] and btn_level[1] are 0 and btn_release[0] pulses once.
  - raw_btn[1] dropped while btn 0 stays held. Required: btn_press[0] pulses again once s[1] falls.
- Reset mid-operation: reset=0 for one edge during an active repeat on channel 2 with raw still high. Required: all outputs 0 next cycle with no release pulse; btn_press[2] again 6 edges after reset deasserts.
- Glitch immunity: a single-cycle raw pulse on every channel. Required: no output activity.
